med_ctrl: RTL



---
 rtl/med_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/med_ctrl.sv
// Control sequencer for the 9-pixel median datapath: turns a burst of pixel strobes
// into the load / compare / bypass schedule and flags the cycle that DO holds the median.
module med_ctrl #(
  parameter int NB_PIXEL = 9,
  parameter int CNT_W    = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic DSI,
  output logic MED_DSI,
  output logic MED_BYP,
  output logic DSO,
  output logic BUSY,
  output logic ERR
);

  localparam int NB_PASS = (NB_PIXEL + 1) / 2;
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(NB_PIXEL - 1);
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NB_PASS - 1);
  localparam logic [CNT_W-1:0] CMP_BASE  = CNT_W'(NB_PIXEL - 2);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, CMP, BYP, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pass, pass_nxt;
  logic [CNT_W-1:0] cmp_last;

  // Pass p compares NB_PIXEL-1-p times, so its last compare index is NB_PIXEL-2-p.
  assign cmp_last = CMP_BASE - pass;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      pass  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pass  <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pass_nxt  = pass;
    MED_DSI   = 1'b0;
    MED_BYP   = 1'b1;
    DSO       = 1'b0;
    BUSY      = 1'b0;
    ERR       = 1'b0;
    case (state)
      IDLE: begin
        MED_DSI = DSI;
        if (DSI) begin
          cnt_nxt   = ONE;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        MED_DSI = DSI;
        BUSY    = 1'b1;
        if (DSI) begin
          if (cnt == LAST_PIX) begin
            cnt_nxt   = '0;
            pass_nxt  = '0;
            state_nxt = CMP;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end else begin
          // Short burst: the partial window is abandoned.
          ERR       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      CMP: begin
        MED_BYP = 1'b0;
        BUSY    = 1'b1;
        ERR     = DSI;
        if (cnt == cmp_last) begin
          cnt_nxt   = '0;
          state_nxt = (pass == LAST_PASS) ? DONE : BYP;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      BYP: begin
        BUSY = 1'b1;
        ERR  = DSI;
        if (cnt == pass) begin
          cnt_nxt   = '0;
          pass_nxt  = (pass == LAST_PASS) ? pass : pass + ONE;
          state_nxt = CMP;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      DONE: begin
        MED_DSI = DSI;
        DSO     = 1'b1;
        // A strobe here is pixel 0 of the next window.
        if (DSI) begin
          cnt_nxt   = ONE;
          state_nxt = LOAD;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        pass_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
